// File: rtl/idct_pkg.sv
// Shared IDCT types: FSM state encoding, datapath widths and the cosine coefficient type.
// The coefficient type is also used by the column pass.
package idct_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int IDCT_S_W     = 16;
  localparam int IDCT_ACC_W   = 32;
  localparam int IDCT_T_SHIFT = 8;

  // cos((2j+1)*i*pi/16) * 2048, truncated toward zero; row 0 is 2048/sqrt(2)
  typedef logic signed [11:0] coef_t;

endpackage

// File: rtl/idct_row_mac_get_c_values.sv
// Combinational IDCT cosine table C[i][j]; zero latency, no flow control.
// The angle (2j+1)*i mod 32 is folded onto one quadrant of eight magnitudes plus a sign.
module get_c_values
  import idct_pkg::*;
(
  input  logic [2:0] i,
  input  logic [2:0] j,
  output coef_t      c_val
);

  logic [4:0]  m;
  logic [4:0]  idx;
  logic        neg;
  logic [11:0] mag;

  assign m = {1'b0, j, 1'b1} * {2'b00, i};

  always_comb begin
    idx = m;
    neg = 1'b0;
    if (m > 5'd8 && m <= 5'd16) begin
      idx = 5'd16 - m;
      neg = 1'b1;
    end else if (m > 5'd16 && m < 5'd24) begin
      idx = m - 5'd16;
      neg = 1'b1;
    end else if (m >= 5'd24) begin
      idx = 5'd0 - m;
    end
  end

  // idx 0 (m = 0 or 16) only arises for i == 0, which is overridden below
  always_comb begin
    case (idx)
      5'd1:    mag = 12'd2008;
      5'd2:    mag = 12'd1892;
      5'd3:    mag = 12'd1702;
      5'd4:    mag = 12'd1448;
      5'd5:    mag = 12'd1137;
      5'd6:    mag = 12'd783;
      5'd7:    mag = 12'd399;
      default: mag = 12'd0;
    endcase
  end

  assign c_val = (i == 3'd0) ? coef_t'(12'sd1448)
               : (neg ? -coef_t'(mag) : coef_t'(mag));

endmodule

// File: rtl/idct_row_mac.sv
// Row pass of the 8x8 IDCT (T = S' x C), one MAC per cycle; first T write 10 cycles after start.
// hold freezes read issue for one cycle per cycle high; in-flight reads still drain.
module idct_row_mac
  import idct_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int S_BASE_ADDR = 0,
  parameter int T_BASE_ADDR = 64,
  parameter int S_W         = IDCT_S_W,
  parameter int ACC_W       = IDCT_ACC_W,
  parameter int T_SHIFT     = IDCT_T_SHIFT
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    start,
  input  logic                    hold,
  output logic [ADDR_W-1:0]       S_address,
  input  logic signed [S_W-1:0]   S_read_data,
  output logic [ADDR_W-1:0]       T_address,
  output logic signed [ACC_W-1:0] T_write_data,
  output logic                    T_write_en,
  output logic                    busy,
  output logic                    done
);

  state_t state;

  // next element to issue
  logic [2:0] r_q, c_q, k_q;

  // issue stage: address on the RAM port this cycle
  logic       iss_vld;
  logic [2:0] iss_r, iss_c, iss_k;

  // data stage: S_read_data valid this cycle
  logic       dat_vld;
  logic [2:0] dat_r, dat_c, dat_k;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s_ext, c_ext, prod, sum;
  coef_t                   coef;

  logic can_issue, last_issue;

  assign can_issue  = (state == IDLE && start) || (state == RUN && !hold);
  assign last_issue = can_issue && (r_q == 3'd7) && (c_q == 3'd7) && (k_q == 3'd7);

  get_c_values u_c_values (
    .i     (dat_k),
    .j     (dat_c),
    .c_val (coef)
  );

  assign s_ext = ACC_W'(S_read_data);
  assign c_ext = ACC_W'(coef);
  assign prod  = s_ext * c_ext;
  assign sum   = ((dat_k == 3'd0) ? '0 : acc) + prod;

  assign busy = (state == RUN) || (state == FLUSH);
  assign done = (state == DONE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      r_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      iss_vld      <= 1'b0;
      iss_r        <= '0;
      iss_c        <= '0;
      iss_k        <= '0;
      dat_vld      <= 1'b0;
      dat_r        <= '0;
      dat_c        <= '0;
      dat_k        <= '0;
      acc          <= '0;
      S_address    <= '0;
      T_address    <= '0;
      T_write_data <= '0;
      T_write_en   <= 1'b0;
    end else begin
      iss_vld <= can_issue;
      if (can_issue) begin
        S_address <= ADDR_W'(S_BASE_ADDR) + ADDR_W'({r_q, k_q});
        iss_r     <= r_q;
        iss_c     <= c_q;
        iss_k     <= k_q;
        // 3-bit counters wrap to zero after the last element, ready for the next block
        k_q <= k_q + 3'd1;
        if (k_q == 3'd7) begin
          c_q <= c_q + 3'd1;
          if (c_q == 3'd7) r_q <= r_q + 3'd1;
        end
      end

      dat_vld <= iss_vld;
      dat_r   <= iss_r;
      dat_c   <= iss_c;
      dat_k   <= iss_k;

      T_write_en <= 1'b0;
      if (dat_vld) begin
        acc <= sum;
        if (dat_k == 3'd7) begin
          T_write_data <= sum >>> T_SHIFT;
          T_address    <= ADDR_W'(T_BASE_ADDR) + ADDR_W'({dat_r, dat_c});
          T_write_en   <= 1'b1;
        end
      end

      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last_issue) state <= FLUSH;
        FLUSH:   if (T_write_en) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_row_mac.sv
// Bench for idct_row_mac: S' RAM model, cosine-based reference IDCT row pass, directed and random blocks.
module tb_idct_row_mac;

  logic               Clock = 1'b0;
  logic               Resetn = 1'b0;
  logic               start = 1'b0;
  logic               hold = 1'b0;
  logic [6:0]         S_address;
  logic signed [15:0] S_read_data;
  logic [6:0]         T_address;
  logic signed [31:0] T_write_data;
  logic               T_write_en;
  logic               busy;
  logic               done;

  idct_row_mac dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .start        (start),
    .hold         (hold),
    .S_address    (S_address),
    .S_read_data  (S_read_data),
    .T_address    (T_address),
    .T_write_data (T_write_data),
    .T_write_en   (T_write_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 Clock = ~Clock;

  logic signed [15:0] sram [0:63];
  always @(posedge Clock)
    S_read_data <= (S_address < 7'd64) ? sram[S_address[5:0]] : 16'sh7fff;

  int     checks = 0;
  int     errors = 0;
  int     s_val [64];
  longint t_ref [64];
  int     wr_addr [$];
  longint wr_data [$];
  int     wr_cyc [$];
  int     cyc;
  int     done_cyc;
  int     busy_bad;
  int     wr_bad;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cval(input int i, input int j);
    real pi;
    pi = 3.14159265358979323846;
    if (i == 0) return $rtoi(2048.0 / $sqrt(2.0));
    return $rtoi(2048.0 * $cos(real'((2 * j + 1) * i) * pi / 16.0));
  endfunction

  task automatic prepare();
    for (int e = 0; e < 64; e++) begin
      longint acc_m;
      acc_m = 0;
      for (int k = 0; k < 8; k++)
        acc_m += longint'(s_val[8 * (e / 8) + k]) * longint'(cval(k, e % 8));
      t_ref[e] = acc_m >>> 8;
    end
    for (int a = 0; a < 64; a++) sram[a] = 16'(s_val[a]);
  endtask

  task automatic fill(input int v);
    for (int a = 0; a < 64; a++) s_val[a] = v;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 64; a++) s_val[a] = int'($signed(16'($urandom)));
  endtask

  // Runs one block; hold is high in cycles [h_start, h_start+h_len); a stray start pulse at restart_cyc.
  task automatic run_block(input string name, input int h_start, input int h_len, input int restart_cyc);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    busy_bad = 0;
    done_cyc = -1;
    prepare();
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    cyc = 1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge Clock);
      start = (cyc == restart_cyc);
      hold  = (cyc >= h_start) && (cyc < h_start + h_len);
      if (T_write_en) begin
        wr_addr.push_back(int'(T_address));
        wr_data.push_back(longint'(T_write_data));
        wr_cyc.push_back(cyc);
      end
      if (busy !== (cyc <= 514 + h_len)) busy_bad++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge Clock);
      cyc++;
    end
    start = 1'b0;
    hold  = 1'b0;
    check({name, " done_cycle"}, done_cyc, 515 + h_len);
    check({name, " write_count"}, wr_data.size(), 64);
    check({name, " busy_window"}, busy_bad, 0);
    for (int e = 0; e < 64; e++) begin
      if (e < wr_data.size()) begin
        check($sformatf("%s T[%0d] data", name, e), wr_data[e], t_ref[e]);
        check($sformatf("%s T[%0d] addr", name, e), wr_addr[e], 64 + e);
        if (h_len == 0) check($sformatf("%s T[%0d] cycle", name, e), wr_cyc[e], 8 * e + 10);
      end
    end
    @(negedge Clock);
    check({name, " done_pulse_width"}, done, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge Clock);
    check("reset outputs", {S_address, T_address, T_write_data, T_write_en, busy, done}, 0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    fill(0);
    run_block("zeros", 0, 0, 0);

    fill(0);
    s_val[0] = 256;
    run_block("dc", 0, 0, 0);
    for (int c = 0; c < 8; c++)
      if (c < wr_data.size()) check($sformatf("dc T[0][%0d]", c), wr_data[c], 1448);
    if (wr_data.size() > 9) check("dc T[1][0]", wr_data[8], 0);

    fill(0);
    s_val[1] = -256;
    run_block("ac1", 0, 0, 0);
    if (wr_data.size() >= 8) begin
      check("ac1 T[0][0]", wr_data[0], -2008);
      check("ac1 T[0][3]", wr_data[3], -399);
      check("ac1 T[0][4]", wr_data[4], 399);
      check("ac1 T[0][7]", wr_data[7], 2008);
    end

    fill(-32768);
    run_block("min", 0, 0, 0);
    for (int r = 0; r < 8; r++)
      if (8 * r < wr_data.size()) check($sformatf("min T[%0d][0]", r), wr_data[8 * r], -1384576);

    fill(0);
    s_val[0] = 256;
    run_block("dc_hold", 100, 10, 0);

    fill_random();
    run_block("rand_hold", $urandom_range(20, 400), $urandom_range(1, 20), 0);

    fill_random();
    run_block("rand", 0, 0, 0);

    // Reset in the middle of a block
    fill_random();
    prepare();
    @(negedge Clock);
    start = 1'b1;
    @(posedge Clock);
    cyc = 1;
    @(negedge Clock);
    start = 1'b0;
    while (cyc < 200) begin
      @(posedge Clock);
      cyc++;
    end
    #2;
    Resetn = 1'b0;
    #1;
    check("async reset outputs", {S_address, T_address, T_write_data, T_write_en, busy, done}, 0);
    wr_bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clock);
      if (T_write_en !== 1'b0 || busy !== 1'b0) wr_bad++;
    end
    Resetn = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge Clock);
      if (T_write_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) wr_bad++;
    end
    check("post reset quiet", wr_bad, 0);

    fill_random();
    run_block("after_reset_restart", 0, 0, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
